pwm_capture: RTL and testbench

PWM capture block: the receive end of the PWM link. It measures an incoming PWM waveform and reports its high time (duty) and period in clock cycles. The output values use the same duty/period scale as the on-chip `pwm_module` generator, so a generator loop-back reads back its own settings. It sits beside `pwm_module` in the Tiny Tapeout top level, with `pwm_in` taken from an input pin and the results presented to the output/bidirectional pins or to downstream logic.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_in_sync.sv | 32 +++
 rtl/pwm_capture.sv | 132 +++++++++++++
 tb/tb_pwm_capture.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types for the PWM capture path.
// Holds the capture FSM state encoding and synchronizer depth.
package pwm_pkg;

  typedef enum logic [1:0] {
    ARM,
    WAIT_RISE,
    HIGH,
    LOW
  } state_e;

  localparam logic [1:0] SYNC_DEPTH = 2'd2;

endpackage

// File: rtl/pwm_in_sync.sv
// pwm_in_sync: 2-flop synchronizer plus edge detect for a pin input.
// pwm_s is the synchronized level; rise/fall are one-cycle strobes.
module pwm_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= pwm_in;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign pwm_s = sync_q;
  assign rise  = sync_q & ~dly_q;
  assign fall  = ~sync_q & dly_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of pwm_in,
// in clock cycles, with saturation and stuck-input timeout.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] MAX  = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic pwm_s;
  logic rise;
  logic fall;

  pwm_in_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .pwm_s (pwm_s),
    .rise  (rise),
    .fall  (fall)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             tout_q, tout_d;
  logic [1:0]       settle_q, settle_d;
  logic [WIDTH-1:0] cnt_inc;
  logic             settled;

  // Synchronizer flops read 0 right after reset whatever the pin does,
  // so ARM ignores pwm_s until real samples have reached it.
  assign settled  = (settle_q == SYNC_DEPTH);
  assign settle_d = settled ? settle_q : settle_q + 2'd1;
  assign cnt_inc  = (cnt_q == MAX) ? MAX : cnt_q + ONE;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    high_d   = high_q;
    duty_d   = duty_q;
    period_d = period_q;
    valid_d  = 1'b0;
    tout_d   = tout_q;
    unique case (state_q)
      ARM: begin
        if (settled && !pwm_s) begin
          state_d = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (rise) begin
          cnt_d   = ONE;
          state_d = HIGH;
        end
      end
      HIGH: begin
        cnt_d = cnt_inc;
        if (fall) begin
          high_d  = cnt_q;
          state_d = LOW;
        end else if (cnt_q == MAX) begin
          duty_d   = MAX;
          period_d = ZERO;
          valid_d  = 1'b1;
          tout_d   = 1'b1;
          state_d  = ARM;
        end
      end
      LOW: begin
        cnt_d = cnt_inc;
        if (rise) begin
          duty_d   = high_q;
          period_d = cnt_q;
          valid_d  = 1'b1;
          tout_d   = 1'b0;
          cnt_d    = ONE;
          state_d  = HIGH;
        end else if (cnt_q == MAX) begin
          duty_d   = ZERO;
          period_d = ZERO;
          valid_d  = 1'b1;
          tout_d   = 1'b1;
          state_d  = WAIT_RISE;
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARM;
      cnt_q    <= ZERO;
      high_q   <= ZERO;
      duty_q   <= ZERO;
      period_q <= ZERO;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
      settle_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
      settle_q <= settle_d;
    end
  end

  assign duty    = duty_q;
  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = tout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: run-length reference model of the PWM capture rules,
// driven with directed and $urandom waveforms.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pwm_in = 1'b0;
  logic [7:0] duty;
  logic [7:0] period;
  logic       valid;
  logic       timeout;

  pwm_capture #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .duty   (duty),
    .period (period),
    .valid  (valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e;
    int d;
    int p;
    int t;
  } rep_t;

  bit   wave[$];
  rep_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   first_d, first_p, first_t;
  int   n_valid, n_tout;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_run(bit lvl, int n);
    repeat (n) wave.push_back(lvl);
  endtask

  function automatic void push(int e, int d, int p, int t);
    rep_t x;
    x.e = e;
    x.d = d;
    x.p = p;
    x.t = t;
    if (e <= wave.size() + 2) exp_q.push_back(x);
  endfunction

  // Reports in terms of runs: wave[i] is the pin level sampled at
  // edge i+1; a rise at index i is reported after edge i+3.
  task automatic model();
    int n, i, r, h, l;
    bit done, meas;
    n = wave.size();
    exp_q.delete();
    i = 0;
    while (i < n && wave[i]) i++;
    done = 0;
    while (!done) begin
      while (i < n && !wave[i]) i++;
      if (i >= n) begin
        done = 1;
      end else begin
        r = i;
        meas = 1;
        while (meas) begin
          h = 0;
          while (r + h < n && wave[r+h]) h++;
          if (h >= 256) begin
            push(r + 258, 255, 0, 1);
            i = r + 256;
            while (i < n && wave[i]) i++;
            meas = 0;
          end else if (r + h >= n) begin
            meas = 0;
            done = 1;
          end else begin
            l = 0;
            while (r + h + l < n && !wave[r+h+l]) l++;
            if (h + l <= 255 || (h == 255 && l == 1)) begin
              if (r + h + l >= n) begin
                meas = 0;
                done = 1;
              end else begin
                push(r + h + l + 3, h, (h + l > 255) ? 255 : h + l, 0);
                r = r + h + l;
              end
            end else begin
              push(r + ((h == 255) ? 259 : 258), 0, 0, 1);
              i = r + ((h == 255) ? 257 : 256);
              meas = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic do_reset(bit lvl, int cyc);
    rst = 1'b1;
    pwm_in = lvl;
    repeat (cyc) @(posedge clk);
    #1;
    chk("reset_duty", duty, 0);
    chk("reset_period", period, 0);
    chk("reset_valid", valid, 0);
    chk("reset_timeout", timeout, 0);
  endtask

  task automatic run();
    int n;
    logic [7:0] pd, pp;
    logic pt, pv;
    rep_t x;
    n = wave.size();
    model();
    pd = 0; pp = 0; pt = 0; pv = 0;
    n_valid = 0; n_tout = 0;
    first_d = -1; first_p = -1; first_t = -1;
    rst = 1'b0;
    pwm_in = wave[0];
    for (int e = 1; e <= n + 2; e++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        chk("valid_back_to_back", pv, 0);
        if (n_valid == 0) begin
          first_d = duty;
          first_p = period;
          first_t = timeout;
        end
        n_valid++;
        if (timeout) n_tout++;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid_cycle", e, -1);
        end else begin
          x = exp_q.pop_front();
          chk("valid_cycle", e, x.e);
          chk("duty", duty, x.d);
          chk("period", period, x.p);
          chk("timeout", timeout, x.t);
        end
      end else begin
        chk("hold_duty", duty, pd);
        chk("hold_period", period, pp);
        chk("hold_timeout", timeout, pt);
      end
      pd = duty; pp = period; pt = timeout; pv = valid;
      pwm_in = (e < n) ? wave[e] : wave[n-1];
    end
    chk("missing_reports", exp_q.size(), 0);
    wave.delete();
  endtask

  initial begin
    bit lvl;
    int len;

    // high at reset release must not be measured
    do_reset(1'b1, 3);
    add_run(1, 10);
    add_run(0, 5);
    repeat (4) begin add_run(1, 3); add_run(0, 5); end
    add_run(1, 2);
    run();
    chk("arm_first_duty", first_d, 3);
    chk("arm_first_period", first_p, 8);
    chk("arm_first_timeout", first_t, 0);

    // generator loop-back: 64 of 255, period exactly MAX
    do_reset(1'b0, 2);
    add_run(0, 4);
    repeat (6) begin add_run(1, 64); add_run(0, 191); end
    add_run(1, 64);
    add_run(0, 20);
    run();
    chk("loop_first_duty", first_d, 64);
    chk("loop_first_period", first_p, 255);
    chk("loop_valids", n_valid, 6);
    chk("loop_timeouts", n_tout, 0);

    // minimum 1/1 waveform
    do_reset(1'b0, 2);
    add_run(0, 3);
    repeat (10) begin add_run(1, 1); add_run(0, 1); end
    add_run(0, 3);
    run();
    chk("min_first_duty", first_d, 1);
    chk("min_first_period", first_p, 2);
    chk("min_valids", n_valid, 9);

    // stuck low, then recovery
    do_reset(1'b0, 2);
    add_run(0, 3);
    add_run(1, 5);
    add_run(0, 300);
    repeat (3) begin add_run(1, 4); add_run(0, 4); end
    add_run(1, 4);
    add_run(0, 2);
    run();
    chk("low_first_timeout", first_t, 1);
    chk("low_first_duty", first_d, 0);
    chk("low_first_period", first_p, 0);
    chk("low_timeouts", n_tout, 1);
    chk("low_valids", n_valid, 4);

    // stuck high, then recovery
    do_reset(1'b0, 2);
    add_run(0, 3);
    add_run(1, 300);
    add_run(0, 4);
    repeat (3) begin add_run(1, 4); add_run(0, 4); end
    add_run(1, 4);
    add_run(0, 2);
    run();
    chk("high_first_timeout", first_t, 1);
    chk("high_first_duty", first_d, 255);
    chk("high_first_period", first_p, 0);
    chk("high_timeouts", n_tout, 1);
    chk("high_valids", n_valid, 4);

    // reset in the middle of a HIGH phase
    do_reset(1'b0, 2);
    add_run(0, 2);
    repeat (3) begin add_run(1, 3); add_run(0, 4); end
    add_run(1, 5);
    run();
    do_reset(1'b1, 1);
    add_run(1, 6);
    repeat (3) begin add_run(0, 3); add_run(1, 2); end
    add_run(0, 3);
    run();
    chk("midrst_first_duty", first_d, 2);
    chk("midrst_first_period", first_p, 5);
    chk("midrst_valids", n_valid, 2);

    // random run lengths, occasionally long enough to saturate
    repeat (4) begin
      lvl = 1'($urandom_range(0, 1));
      do_reset(lvl, $urandom_range(1, 3));
      repeat (30) begin
        if ($urandom_range(0, 9) == 0) len = $urandom_range(200, 300);
        else len = $urandom_range(1, 20);
        add_run(lvl, len);
        lvl = !lvl;
      end
      run();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
